hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Pipeline hazard/stall unit for the EV22 core. Every instruction leaving
//   decode is tracked through a DEPTH-entry in-flight scoreboard. The unit
//   raises a combinational hold on WR, carry, register, jump and memory-read
//   hazards, and inserts a bubble into the scoreboard whenever it holds.
//
//   Optional feature macro: HAZARD_FWD_EN
//     defined   - a register match found only in the oldest slot is forwarded
//                 (no hold, fwd_hit=1)
//     undefined - every register match holds, fwd_hit tied 0
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   issue_valid in   decode holds a valid instruction
//   issue_type  in   [0]WR_rd [1]WR_wr [2]R_rd [3]R_wr [4]C_rd [5]C_wr [6]Jump
//   issue_src   in   source register select
//   issue_dst   in   destination register select
//   issue_mr    in   decode instruction reads memory
//   flush       in   kill decode instruction and all in-flight entries
//   hold        out  stall decode (combinational)
//   fwd_hit     out  R operand forwarded from the writeback slot
//   inflight    out  valid bit per slot, bit 0 = youngest
//   stall_cnt   out  saturating count of hold cycles
module hazard_scoreboard #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int MEM_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [6:0]       issue_type,
    input  logic [REG_W-1:0] issue_src,
    input  logic [REG_W-1:0] issue_dst,
    input  logic             issue_mr,
    input  logic             flush,
    output logic             hold,
    output logic             fwd_hit,
    output logic [DEPTH-1:0] inflight,
    output logic [15:0]      stall_cnt
);

    localparam int MW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    // Only the writer bits of a tracked instruction can create a later
    // hazard, so each slot keeps {C_write, R_write, WR_write} plus dst.
    logic             slot_valid_reg [DEPTH];
    logic [2:0]       slot_wmask_reg [DEPTH];
    logic [REG_W-1:0] slot_dst_reg   [DEPTH];

    logic [MW-1:0]    mem_cnt_reg;
    logic [15:0]      stall_cnt_reg;

    logic [DEPTH-1:0] any_v;
    logic [DEPTH-1:0] wr_w;
    logic [DEPTH-1:0] c_w;
    logic [DEPTH-1:0] r_match;
    logic             reg_hz;
    logic             hz;
    logic             accept;

    // Per-slot hazard terms
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign any_v[gi]   = slot_valid_reg[gi];
        assign wr_w[gi]    = slot_valid_reg[gi] && slot_wmask_reg[gi][0];
        assign c_w[gi]     = slot_valid_reg[gi] && slot_wmask_reg[gi][2];
        assign r_match[gi] = slot_valid_reg[gi] && slot_wmask_reg[gi][1]
                             && (slot_dst_reg[gi] == issue_src);
        assign inflight[gi] = slot_valid_reg[gi];
    end

`ifdef HAZARD_FWD_EN
    logic r_young;
    logic fwd_cand;

    // A producer in the oldest slot is at writeback and can be bypassed,
    // but only if no younger producer of the same register exists.
    assign r_young  = |r_match[DEPTH-2:0];
    assign reg_hz   = issue_type[2] && r_young;
    assign fwd_cand = issue_type[2] && r_match[DEPTH-1] && !r_young;
    assign fwd_hit  = accept && fwd_cand;
`else
    assign reg_hz  = issue_type[2] && (|r_match);
    assign fwd_hit = 1'b0;
`endif

    assign hz = (issue_type[6] && (|any_v))
             || (issue_type[0] && (|wr_w))
             || (issue_type[4] && (|c_w))
             || reg_hz
             || (issue_mr && (|wr_w));

    assign hold   = !flush && ((issue_valid && hz) || (mem_cnt_reg != '0));
    assign accept = issue_valid && !hold && !flush;

    // Scoreboard shift: slot 0 takes the accepted instruction or a bubble.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_wmask_reg[gi] <= '0;
                    slot_dst_reg[gi]   <= '0;
                end else begin
                    slot_valid_reg[gi] <= accept;
                    slot_wmask_reg[gi] <= {issue_type[5], issue_type[3], issue_type[1]};
                    slot_dst_reg[gi]   <= issue_dst;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_wmask_reg[gi] <= '0;
                    slot_dst_reg[gi]   <= '0;
                end else begin
                    slot_valid_reg[gi] <= slot_valid_reg[gi-1] && !flush;
                    slot_wmask_reg[gi] <= slot_wmask_reg[gi-1];
                    slot_dst_reg[gi]   <= slot_dst_reg[gi-1];
                end
            end
        end
    end

    // Memory-wait counter; flush wins over a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt_reg <= '0;
        end else if (flush) begin
            mem_cnt_reg <= '0;
        end else if (accept && issue_mr) begin
            mem_cnt_reg <= MW'(MEM_WAIT);
        end else if (mem_cnt_reg != '0) begin
            mem_cnt_reg <= mem_cnt_reg - MW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (hold && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule
